// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer: packs a valid/ready byte stream little-endian into 32-bit
// words for the write side of the dual-clock FIFO. Short tail words are padded
// with PAD_BYTE. At most one finished word waits for the FIFO, so fifo_full
// back-pressures the byte stream directly.
// Optional build macro PACKER_STATS_EN adds word/packet counters (word_cnt,
// pkt_cnt) and the CNT_W parameter.
module fifo_wr_packer #(
    parameter logic [7:0]  PAD_BYTE = 8'h00
`ifdef PACKER_STATS_EN
    ,
    parameter int unsigned CNT_W    = 16
`endif
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             fifo_full,
    output logic             wrt,
    output logic [31:0]      data_out
`ifdef PACKER_STATS_EN
    ,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] pkt_cnt
`endif
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LANES  = 4;
    localparam int unsigned WORD_W = BYTE_W * LANES;

    logic [WORD_W-1:0] asm_q, asm_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [1:0]        lane_q, lane_d;
    logic              pend_q, pend_d;
    logic [WORD_W-1:0] merged;
    logic              acc;
    logic              word_done;

    // Handshake and write strobe are combinational on the single pending slot
    assign in_ready  = ~pend_q | ~fifo_full;
    assign wrt       = pend_q & ~fifo_full;
    assign data_out  = data_q;
    assign acc       = in_valid & in_ready;
    assign word_done = acc & ((lane_q == 2'd3) | in_last);

    // Current byte merged into the assembly word, higher lanes padded
    always_comb begin
        merged = asm_q;
        for (int i = 0; i < int'(LANES); i++) begin
            if (2'(i) == lane_q) begin
                merged[BYTE_W*i +: BYTE_W] = in_data;
            end else if (2'(i) > lane_q) begin
                merged[BYTE_W*i +: BYTE_W] = PAD_BYTE;
            end
        end
    end

    // Next-state: lane advance, word completion and pending-slot handover
    always_comb begin
        asm_d  = asm_q;
        data_d = data_q;
        lane_d = lane_q;
        pend_d = pend_q;
        if (wrt) begin
            pend_d = 1'b0;
        end
        if (word_done) begin
            data_d = merged;
            pend_d = 1'b1;
            lane_d = 2'd0;
            asm_d  = {LANES{PAD_BYTE}};
        end else if (acc) begin
            asm_d  = merged;
            lane_d = lane_q + 2'd1;
        end
    end

    // State registers, synchronous reset discards partial and pending words
    always_ff @(posedge clk1) begin
        if (rst) begin
            asm_q  <= '0;
            data_q <= '0;
            lane_q <= '0;
            pend_q <= 1'b0;
        end else begin
            asm_q  <= asm_d;
            data_q <= data_d;
            lane_q <= lane_d;
            pend_q <= pend_d;
        end
    end

`ifdef PACKER_STATS_EN
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    // Free-running wrap-around counters of written words and finished packets
    always_comb begin
        word_cnt_d = word_cnt_q + CNT_W'(wrt);
        pkt_cnt_d  = pkt_cnt_q + CNT_W'(acc & in_last);
    end

    // Counter registers
    always_ff @(posedge clk1) begin
        if (rst) begin
            word_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign word_cnt = word_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;
`endif

endmodule

// File: doc/fifo_wr_packer.md
Name: fifo_wr_packer

Overview:
- Write-side feeder for the dual-clock 32-bit FIFO; runs entirely on clk1.
- Accepts an 8-bit byte stream with a valid/ready handshake and packet-end marker.
- Packs bytes little-endian into 32-bit words, padding short tail words.
- Drives the FIFO write strobe and data, honouring the FIFO full flag as backpressure.

Parameters:
- PAD_BYTE, 8'h00, fill value for unused lanes of a tail word.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk1  in  1  write-domain clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset, sampled on clk1.
- in_data  in  8  input byte.
- in_valid  in  1  in_data valid.
- in_last  in  1  byte is the last of a packet; qualified by in_valid.
- in_ready  out  1  block can accept a byte this cycle.
- fifo_full  in  1  FIFO full flag, write side.
- wrt  out  1  FIFO write strobe; one word is written per cycle high.
- data_out  out  32  word to FIFO data_in.
- word_cnt  out  CNT_W  words written (PACKER_STATS_EN only).
- pkt_cnt  out  CNT_W  packets completed (PACKER_STATS_EN only).

Behaviour:
- Reset values: in_ready=1 (follows from pend=0), wrt=0, data_out=0, lane=0, pend=0, assembly register=0, counters=0.
- Reset mid-operation discards any partial word and any pending word; nothing is written.
- Internal state: assembly register asm[31:0], lane index lane[1:0], output register data_out, pend flag (word waiting).
- Accept condition: acc = in_valid & in_ready.
- On acc, the byte goes to asm[8*lane+7 : 8*lane].
- Word complete: acc & (lane==3 | in_last).
- On a completed word:
  - data_out <= asm with the current byte merged; lanes above the current lane are set to PAD_BYTE.
  - pend <= 1.
  - lane <= 0.
  - asm <= {4{PAD_BYTE}}.
- On acc without completion: lane <= lane+1.
- wrt = pend & ~fifo_full (combinational). The FIFO captures data_out on the same clk1 edge.
- Pend clears on the edge where wrt=1, unless a new word completes on that same edge. In that case pend stays 1 and data_out reloads.
- in_ready = ~pend | ~fifo_full (combinational). There is no skid buffer, and at most one pending word.
- Latency: the completing byte is accepted at edge N; wrt is high in cycle N+1 if fifo_full=0.
- Throughput: one word per 4 accepted bytes; back-to-back single-byte packets sustain 1 word/cycle while not full.
- fifo_full high with pend=1: wrt=0, in_ready=0, data_out held stable.
- Once fifo_full drops, the held word is written in that cycle.
- fifo_full high with pend=0: bytes are still accepted until a word completes.
- in_last on lane 3: no padding.
- in_last on lane 0: the word is {3{PAD_BYTE}, byte}.
- in_last is ignored when in_valid=0.
- Lane index wraps 3->0 naturally. There are no other states: FILL is pend=0, HOLD is pend=1 & fifo_full.

Optional Feature:
- Macro: PACKER_STATS_EN.
- Defined: adds the word_cnt and pkt_cnt output ports.
  - word_cnt increments on each wrt.
  - pkt_cnt increments on each acc & in_last.
  - Both wrap modulo 2^CNT_W and are cleared by rst.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Bytes 11,22,33,44 (last on 44), fifo_full=0 -> one wrt, data_out=32'h44332211, in_ready never low.
- Bytes AA,BB with last on BB, PAD_BYTE=00 -> wrt with data_out=32'h0000BBAA; next word starts at lane 0.
- fifo_full=1 while the word 32'h44332211 is pending -> wrt=0, in_ready=0, data_out stable for 5 cycles; fifo_full=0 -> single wrt with the same value.
- Eight single-byte packets 01..08 with last on each, fifo_full=0 -> eight consecutive cycles of wrt, data_out=32'h00000001..32'h00000008.
- rst asserted after 2 bytes of a 4-byte packet -> no wrt; next packet 55,66,77,88 -> wrt with 32'h88776655.
- With PACKER_STATS_EN: 3 packets totalling 10 bytes (4+4+2) -> word_cnt=3, pkt_cnt=3.
